// File: rtl/gpp_multicycle_p.sv
// Multi-cycle MIPS-subset processor with a unified instruction/data memory port.
// Each instruction is fetched, executed, and (for lw/sw) followed by one memory access.
// The register file is internal. Dbg_Addr/Dbg_Data gives a combinational read port into it.
module gpp_multicycle_p #(
  parameter int D_WIDTH  = 32,
  parameter int A_WIDTH  = 8,
  parameter int NREG     = 32,
  parameter int PROG_LEN = 9
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Start,
  output logic [A_WIDTH-1:0] o_Addr,
  input  logic [D_WIDTH-1:0] i_RData,
  output logic [D_WIDTH-1:0] o_WData,
  output logic               o_RW,
  output logic               o_En,
  input  logic               i_Ready,
  output logic               o_Done,
  output logic               o_Error,
  input  logic [4:0]         i_Dbg_Addr,
  output logic [D_WIDTH-1:0] o_Dbg_Data
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_DONE} state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] FN_SLL   = 6'd0;
  localparam logic [5:0] FN_SRL   = 6'd2;
  localparam logic [5:0] FN_MUL   = 6'd24;
  localparam logic [5:0] FN_DIV   = 6'd26;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;

  // One extra bit so that a program filling the whole address space still terminates.
  localparam logic [A_WIDTH:0] PROG_END = (A_WIDTH+1)'(PROG_LEN);

  state_t               r_state, w_next;
  logic [A_WIDTH-1:0]   r_pc, r_ea;
  logic [31:0]          r_ir;
  logic [D_WIDTH-1:0]   r_wdata;
  logic                 r_error;
  logic [D_WIDTH-1:0]   r_regs [1:NREG-1];

  logic [D_WIDTH-1:0]   w_regView [32];
  logic [5:0]           w_op, w_fn;
  logic [4:0]           w_rs, w_rt, w_rd, w_sh;
  logic [15:0]          w_imm;
  logic [D_WIDTH-1:0]   w_immExt, w_rsVal, w_rtVal, w_result, w_regData;
  logic [A_WIDTH-1:0]   w_ea, w_target;
  logic [4:0]           w_aluIdx, w_regIdx;
  logic                 w_aluWe, w_regWe, w_illegal, w_branch, w_isMem, w_pcAtEnd;

  // Register 0 and indices beyond NREG read as zero.
  for (genvar g = 0; g < 32; g++) begin : g_view
    if (g == 0 || g >= NREG) begin : g_zero
      assign w_regView[g] = '0;
    end else begin : g_reg
      assign w_regView[g] = r_regs[g];
    end
  end

  assign w_op       = r_ir[31:26];
  assign w_rs       = r_ir[25:21];
  assign w_rt       = r_ir[20:16];
  assign w_rd       = r_ir[15:11];
  assign w_sh       = r_ir[10:6];
  assign w_fn       = r_ir[5:0];
  assign w_imm      = r_ir[15:0];
  assign w_immExt   = {{(D_WIDTH-16){w_imm[15]}}, w_imm};
  assign w_rsVal    = w_regView[w_rs];
  assign w_rtVal    = w_regView[w_rt];
  assign w_ea       = w_rsVal[A_WIDTH-1:0] + w_immExt[A_WIDTH-1:0];
  assign w_target   = r_pc + w_immExt[A_WIDTH-1:0];
  assign w_pcAtEnd  = ({1'b0, r_pc} >= PROG_END);
  assign o_Dbg_Data = w_regView[i_Dbg_Addr];
  assign o_Error    = r_error;

  // Decode the held instruction and compute its ALU result, branch decision and legality.
  always_comb begin
    w_result  = '0;
    w_aluWe   = 1'b0;
    w_aluIdx  = w_rd;
    w_illegal = 1'b0;
    w_branch  = 1'b0;
    w_isMem   = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_aluWe = 1'b1;
        case (w_fn)
          FN_SLL:  w_result = w_rtVal << w_sh;
          FN_SRL:  w_result = w_rtVal >> w_sh;
          FN_MUL:  w_result = w_rsVal * w_rtVal;
          FN_DIV:  w_result = (w_rtVal == '0) ? '1 : w_rsVal / w_rtVal;
          FN_ADD:  w_result = w_rsVal + w_rtVal;
          FN_SUB:  w_result = w_rsVal - w_rtVal;
          default: begin
            w_aluWe   = 1'b0;
            w_illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        w_aluWe  = 1'b1;
        w_aluIdx = w_rt;
        w_result = w_rsVal + w_immExt;
      end
      OP_BEQ:       w_branch = (w_rsVal == w_rtVal);
      OP_BNE:       w_branch = (w_rsVal != w_rtVal);
      OP_LW, OP_SW: w_isMem  = 1'b1;
      default:      w_illegal = 1'b1;
    endcase
  end

  // Register writes come from the ALU at the end of EXEC, or from memory when a load completes.
  always_comb begin
    w_regWe   = 1'b0;
    w_regIdx  = '0;
    w_regData = '0;
    if (r_state == S_EXEC && w_aluWe) begin
      w_regWe   = 1'b1;
      w_regIdx  = w_aluIdx;
      w_regData = w_result;
    end else if (r_state == S_MEM && i_Ready && w_op == OP_LW) begin
      w_regWe   = 1'b1;
      w_regIdx  = w_rt;
      w_regData = i_RData;
    end
  end

  // Next-state logic. The memory port outputs depend only on state, PC and the latched address/data.
  always_comb begin
    w_next  = r_state;
    o_En    = 1'b0;
    o_RW    = 1'b0;
    o_Addr  = '0;
    o_WData = '0;
    o_Done  = 1'b0;
    case (r_state)
      S_IDLE:  if (i_Start) w_next = S_FETCH;
      S_FETCH: begin
        if (w_pcAtEnd) begin
          w_next = S_DONE;
        end else begin
          o_En   = 1'b1;
          o_Addr = r_pc;
          if (i_Ready) w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_illegal)    w_next = S_DONE;
        else if (w_isMem) w_next = S_MEM;
        else              w_next = S_FETCH;
      end
      S_MEM: begin
        o_En    = 1'b1;
        o_Addr  = r_ea;
        o_RW    = (w_op == OP_SW);
        o_WData = r_wdata;
        if (i_Ready) w_next = S_FETCH;
      end
      S_DONE: begin
        o_Done = 1'b1;
        if (i_Start) w_next = S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, PC, IR, latched memory operands and error flag.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      r_ea    <= '0;
      r_wdata <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_FETCH: begin
          if (!w_pcAtEnd && i_Ready) begin
            r_ir <= i_RData[31:0];
            r_pc <= r_pc + 1'b1;
          end
        end
        S_EXEC: begin
          if (w_illegal) begin
            r_error <= 1'b1;
          end else begin
            if (w_branch) r_pc <= w_target;
            if (w_isMem) begin
              r_ea    <= w_ea;
              r_wdata <= w_rtVal;
            end
          end
        end
        S_DONE: begin
          if (i_Start) begin
            r_error <= 1'b0;
            r_pc    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Register file. Writes to index 0 or beyond NREG have no matching entry and are dropped.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      for (int k = 1; k < NREG; k++) r_regs[k] <= '0;
    end else if (w_regWe) begin
      for (int k = 1; k < NREG; k++) begin
        if (w_regIdx == 5'(k)) r_regs[k] <= w_regData;
      end
    end
  end

endmodule

// File: tb/tb_gpp_multicycle_p.sv
// Scoreboard bench for gpp_multicycle_p.
// The stimulus process loads directed programs and queues the expected memory requests and Done results.
// A monitor process checks every request and every Done edge the DUT presents against those queues.
module tb_gpp_multicycle_p;

  localparam int PROG_LEN = 9;

  typedef struct packed {
    logic [7:0]  addr;
    logic        rw;
    logic [31:0] wdata;
  } memTxn_t;

  typedef struct packed {
    logic        err;
    logic [31:0] lat;
  } doneExp_t;

  logic        clk = 1'b0;
  logic        rst, start, ready;
  logic [7:0]  addr;
  logic [31:0] rdata, wdata, dbgData;
  logic        rw, en, done, error;
  logic [4:0]  dbgAddr;

  logic [31:0] prog [0:15];
  logic [31:0] dataMem [0:255];
  memTxn_t     expMem [$];
  doneExp_t    expDone [$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          startCyc = 0;
  int          dataStall = 0;

  gpp_multicycle_p #(.D_WIDTH(32), .A_WIDTH(8), .NREG(16), .PROG_LEN(PROG_LEN)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start), .o_Addr(addr), .i_RData(rdata),
    .o_WData(wdata), .o_RW(rw), .o_En(en), .i_Ready(ready), .o_Done(done),
    .o_Error(error), .i_Dbg_Addr(dbgAddr), .o_Dbg_Data(dbgData)
  );

  always #5 clk = ~clk;

  // Count clock edges so that Done latency can be measured.
  always @(posedge clk) cyc++;

  // Program words live below PROG_LEN. Data lives above it.
  assign rdata = (addr < 8'(PROG_LEN)) ? prog[addr[3:0]] : dataMem[addr];

  function automatic logic [31:0] rType(input int rs, input int rt, input int rd, input int sh, input int fn);
    rType = {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
  endfunction

  function automatic logic [31:0] iType(input int op, input int rs, input int rt, input int imm);
    iType = {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic checkReg(input int idx, input logic [31:0] expected);
    dbgAddr = idx[4:0];
    #1;
    checkOutput($sformatf("r%0d", idx), dbgData, expected);
  endtask

  task automatic clearProg();
    for (int i = 0; i < 16; i++) prog[i] = 32'd0;
  endtask

  task automatic pushFetch(input int a);
    expMem.push_back('{addr: 8'(a), rw: 1'b0, wdata: 32'd0});
  endtask

  task automatic pushData(input int a, input logic w, input logic [31:0] d);
    expMem.push_back('{addr: 8'(a), rw: w, wdata: d});
  endtask

  // Start a program, wait for Done with a bounded loop, then confirm every queued request was seen.
  task automatic applyStimulus(input logic expErr, input int expLat);
    int n;
    @(negedge clk);
    startCyc = cyc;
    expDone.push_back('{err: expErr, lat: 32'(expLat)});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("startDone", 32'(done), 32'd0);
    checkOutput("startError", 32'(error), 32'd0);
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL doneTimeout: got done=%0b expected 1", done);
    end
    @(negedge clk);
    #2;
    checkOutput("queueDrained", 32'(expMem.size()), 32'd0);
  endtask

  // Memory ready generator. Fetches complete immediately. Data requests wait dataStall cycles.
  initial begin
    int waitCnt;
    waitCnt = 0;
    ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!en) begin
        ready = 1'b0;
        waitCnt = 0;
      end else if (waitCnt >= ((addr >= 8'(PROG_LEN)) ? dataStall : 0)) begin
        ready = 1'b1;
        waitCnt = 0;
      end else begin
        ready = 1'b0;
        waitCnt++;
      end
    end
  end

  // Monitor: compare each request cycle against the queue head and pop when the handshake completes.
  // On each Done rising edge, pop the expected error flag and latency.
  initial begin
    logic prevDone;
    doneExp_t de;
    prevDone = 1'b0;
    for (int i = 0; i < 256; i++) dataMem[i] = 32'd0;
    forever begin
      @(negedge clk);
      #1;
      if (en) begin
        if (expMem.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedRequest: got addr=%h rw=%0b expected no request", addr, rw);
        end else begin
          checkOutput("reqAddr", 32'(addr), 32'(expMem[0].addr));
          checkOutput("reqRW", 32'(rw), 32'(expMem[0].rw));
          if (expMem[0].rw) checkOutput("reqWData", wdata, expMem[0].wdata);
          if (ready) begin
            if (rw) dataMem[addr] = wdata;
            void'(expMem.pop_front());
          end
        end
      end
      if (done && !prevDone) begin
        if (expDone.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedDone: got done=1 expected 0");
        end else begin
          de = expDone.pop_front();
          checkOutput("doneError", 32'(error), 32'(de.err));
          checkOutput("doneLatency", 32'(cyc - startCyc), de.lat);
        end
      end
      prevDone = done;
    end
  end

  // Directed programs.
  initial begin
    logic [31:0] badOp;
    int n;
    badOp = 32'hFC00_0000;
    rst = 1'b1;
    start = 1'b0;
    dbgAddr = 5'd0;
    clearProg();
    repeat (2) @(negedge clk);
    checkOutput("rstEn", 32'(en), 32'd0);
    checkOutput("rstRW", 32'(rw), 32'd0);
    checkOutput("rstAddr", 32'(addr), 32'd0);
    checkOutput("rstWData", wdata, 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstError", 32'(error), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idleEn", 32'(en), 32'd0);
    checkReg(1, 32'd0);

    // Arithmetic, shifts, multiply and divide by zero. A nop in word 8 fills the program.
    clearProg();
    prog[0] = iType(8, 0, 1, 5);
    prog[1] = iType(8, 0, 2, -3);
    prog[2] = rType(1, 2, 3, 0, 32);
    prog[3] = rType(2, 1, 4, 0, 34);
    prog[4] = rType(0, 1, 5, 4, 0);
    prog[5] = rType(0, 4, 6, 28, 2);
    prog[6] = rType(1, 1, 7, 0, 24);
    prog[7] = rType(7, 0, 8, 0, 26);
    for (int a = 0; a < 9; a++) pushFetch(a);
    applyStimulus(1'b0, 20);
    checkReg(0, 32'd0);
    checkReg(1, 32'd5);
    checkReg(2, 32'hFFFF_FFFD);
    checkReg(3, 32'd2);
    checkReg(4, 32'hFFFF_FFF8);
    checkReg(5, 32'h50);
    checkReg(6, 32'hF);
    checkReg(7, 32'd25);
    checkReg(8, 32'hFFFF_FFFF);

    // Store then load with two stall cycles on each data request. The write to r20 must be dropped.
    clearProg();
    prog[0] = iType(43, 0, 1, 20);
    prog[1] = iType(35, 0, 9, 20);
    prog[2] = iType(8, 9, 10, 1);
    prog[3] = iType(8, 0, 20, 7);
    dataStall = 2;
    pushFetch(0);
    pushData(20, 1'b1, 32'd5);
    pushFetch(1);
    pushData(20, 1'b0, 32'd0);
    for (int a = 2; a < 9; a++) pushFetch(a);
    applyStimulus(1'b0, 26);
    checkOutput("mem20", dataMem[20], 32'd5);
    checkReg(9, 32'd5);
    checkReg(10, 32'd6);
    checkReg(20, 32'd0);
    checkReg(4, 32'hFFFF_FFF8);

    // Countdown loop with bne, then a taken beq past the program end.
    clearProg();
    dataStall = 0;
    prog[0] = iType(8, 0, 1, 3);
    prog[1] = iType(8, 1, 1, -1);
    prog[2] = iType(5, 1, 0, -2);
    prog[3] = iType(4, 0, 0, 10);
    pushFetch(0);
    for (int i = 0; i < 3; i++) begin
      pushFetch(1);
      pushFetch(2);
    end
    pushFetch(3);
    applyStimulus(1'b0, 18);
    checkReg(1, 32'd0);

    // Illegal opcode at word 2 halts with Error. A restart clears Error and reruns from word 0.
    clearProg();
    prog[0] = iType(8, 0, 12, 7);
    prog[1] = iType(8, 0, 13, 9);
    prog[2] = badOp;
    prog[3] = iType(8, 0, 12, 1);
    for (int a = 0; a < 3; a++) pushFetch(a);
    applyStimulus(1'b1, 7);
    checkOutput("illegalError", 32'(error), 32'd1);
    checkReg(12, 32'd7);
    checkReg(13, 32'd9);
    for (int a = 0; a < 3; a++) pushFetch(a);
    applyStimulus(1'b1, 7);
    checkReg(12, 32'd7);

    // Reset during a stalled store drops the request and clears all state.
    clearProg();
    prog[0] = iType(8, 0, 14, 77);
    prog[1] = iType(43, 0, 14, 30);
    dataStall = 5;
    pushFetch(0);
    pushFetch(1);
    pushData(30, 1'b1, 32'd77);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(en && rw) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!(en && rw)) begin
      checks++;
      errors++;
      $display("[TB] FAIL storeTimeout: got en=%0b rw=%0b expected 1 1", en, rw);
    end
    @(negedge clk);
    checkReg(14, 32'd77);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midRstEn", 32'(en), 32'd0);
    checkOutput("midRstRW", 32'(rw), 32'd0);
    checkOutput("midRstAddr", 32'(addr), 32'd0);
    checkOutput("midRstWData", wdata, 32'd0);
    checkOutput("midRstDone", 32'(done), 32'd0);
    checkOutput("midRstError", 32'(error), 32'd0);
    checkReg(14, 32'd0);
    checkReg(5, 32'd0);
    checkReg(9, 32'd0);
    expMem.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checkOutput("postRstEn", 32'(en), 32'd0);
    checkOutput("postRstDone", 32'(done), 32'd0);
    checkOutput("mem30", dataMem[30], 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
